// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 round sequencer
package aes_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int AES_ROUND_W     = 4;
  localparam int AES_CORE_LAT    = 20;
  localparam int AES_NUM_ROUNDS  = 10;
  localparam int AES_WDOG_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer in front of the round core
// Optional completed-block counter: define AES_ROUND_CTRL_BLKCNT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES_NUM_ROUNDS,
  parameter int WDOG_CYCLES = AES_WDOG_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLK_W-1:0]   in_text,
  input  logic [AES_BLK_W-1:0]   in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLK_W-1:0]   out_text,
  output logic                   core_enable,
  output logic [AES_ROUND_W-1:0] core_round,
  output logic [AES_BLK_W-1:0]   core_text,
  output logic [AES_BLK_W-1:0]   core_key,
  input  logic [AES_BLK_W-1:0]   core_o_text,
  input  logic [AES_BLK_W-1:0]   core_rkey,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   wdog_err,
  output logic [31:0]            blk_cnt
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [AES_ROUND_W-1:0] LAST_ROUND = AES_ROUND_W'(NUM_ROUNDS - 1);
  // Abort decision is taken one cycle early so the registered pulse lands
  // exactly WDOG_CYCLES cycles after the ISSUE cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 2);

  aes_state_e             state_q;
  logic [AES_ROUND_W-1:0] round_q;
  logic [AES_BLK_W-1:0]   text_q;
  logic [AES_BLK_W-1:0]   key_q;
  logic [AES_BLK_W-1:0]   out_text_q;
  logic                   out_valid_q;
  logic                   wdog_err_q;
  logic [WDOG_W-1:0]      wdog_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      text_q      <= '0;
      key_q       <= '0;
      out_text_q  <= '0;
      out_valid_q <= 1'b0;
      wdog_err_q  <= 1'b0;
      wdog_q      <= '0;
    end else begin
      wdog_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            text_q  <= in_text ^ in_key;
            key_q   <= in_key;
            round_q <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            if (round_q == LAST_ROUND) begin
              out_text_q  <= core_o_text;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT;
            end else begin
              text_q  <= core_o_text;
              key_q   <= core_rkey;
              round_q <= round_q + 1'b1;
              state_q <= ST_ISSUE;
            end
          end else if (wdog_q == WDOG_LAST) begin
            wdog_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Core inputs come straight from registers so they stay put for the whole round.
  assign core_text   = text_q;
  assign core_key    = key_q;
  assign core_round  = round_q;
  assign core_enable = (state_q == ST_ISSUE);

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_text  = out_text_q;
  assign wdog_err  = wdog_err_q;

`ifdef AES_ROUND_CTRL_BLKCNT_EN
  logic [31:0] blk_cnt_q;
  logic [31:0] blk_cnt_d;

  assign blk_cnt_d = blk_cnt_q + 32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl with a behavioural round core
module tb_aes_round_ctrl;

  localparam int NUM_ROUNDS = 10;
  localparam int WDOG       = 32;
  localparam int LATENCY    = 201;

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] AB_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] AB_PT  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] AB_CT  = 128'h320b6a19978511dcfb09dc021d842539;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         core_enable;
  logic [3:0]   core_round;
  logic [127:0] core_text;
  logic [127:0] core_key;
  logic [127:0] core_o_text;
  logic [127:0] core_rkey;
  logic         core_done;
  logic         busy;
  logic         wdog_err;
  logic [31:0]  blk_cnt;
  logic         core_hang;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .core_enable(core_enable), .core_round(core_round), .core_text(core_text),
    .core_key(core_key), .core_o_text(core_o_text), .core_rkey(core_rkey),
    .core_done(core_done), .busy(busy), .wdog_err(wdog_err), .blk_cnt(blk_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AES arithmetic
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input int r);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, t;
    for (int j = 0; j < r; j++) rc = xt(rc);
    t  = {sbox_tab[k[103:96]], sbox_tab[k[127:120]], sbox_tab[k[119:112]],
          sbox_tab[k[111:104]] ^ rc};
    w0 = k[31:0] ^ t;
    w1 = k[63:32] ^ w0;
    w2 = k[95:64] ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input bit last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox_tab[st[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) o[32*c +: 32] = {a3, a2, a1, a0};
      else o[32*c +: 32] = {gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02),
                            a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                            a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                            gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3};
    end
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      k = key_step(k, r);
      s = aes_round(s, k, r == NUM_ROUNDS - 1);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Round core stand-in: done on its counter value 19, reading its inputs late in the round
  int core_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt    <= 0;
      core_o_text <= '0;
      core_rkey   <= '0;
    end else begin
      if (core_enable) core_cnt <= 1;
      else if (core_cnt == 19) core_cnt <= 0;
      else if (core_cnt != 0) core_cnt <= core_cnt + 1;
      if (core_cnt == 18) begin
        core_rkey   <= key_step(core_key, int'(core_round));
        core_o_text <= aes_round(core_text, key_step(core_key, int'(core_round)),
                                 int'(core_round) == NUM_ROUNDS - 1);
      end
    end
  end
  assign core_done = (core_cnt == 19) && !core_hang;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records one result per output handshake
  typedef struct {
    logic [127:0] got;
    logic [127:0] exp;
    int           lat;
    int           n_en;
    bit           rounds_ok;
    bit           stab_ok;
    bit           hold_ok;
  } res_t;

  res_t         res_q[$];
  int           wd_q[$];
  logic [127:0] cur_exp = '0, snap_text = '0, snap_key = '0, held_text = '0;
  logic [3:0]   snap_round = '0;
  int           acc_cyc = 0, issue_cyc = 0, en_cnt = 0, lat_cur = 0, hs_cnt = 0, acc_cnt = 0;
  bit           rounds_ok = 1, stab_ok = 1, hold_ok = 1, pend = 0, prev_ov = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend = 0; hs_cnt = 0; prev_ov = 0;
    end else begin
      if (in_valid && in_ready) begin
        cur_exp = aes_encrypt(in_text, in_key);
        acc_cyc = cyc; acc_cnt++; en_cnt = 0;
        rounds_ok = 1; stab_ok = 1; hold_ok = 1;
      end
      if (core_enable) begin
        if (int'(core_round) != en_cnt || pend) rounds_ok = 0;
        en_cnt++; issue_cyc = cyc; pend = 1;
        snap_text = core_text; snap_key = core_key; snap_round = core_round;
      end else if (pend) begin
        if (core_text !== snap_text || core_key !== snap_key || core_round !== snap_round)
          stab_ok = 0;
        if (core_done) pend = 0;
      end
      if (wdog_err) begin
        wd_q.push_back(cyc - issue_cyc);
        pend = 0;
      end
      if (out_valid && !prev_ov) begin
        lat_cur = cyc - acc_cyc;
        held_text = out_text;
      end
      if (out_valid && out_text !== held_text) hold_ok = 0;
      if (out_valid && out_ready) begin
        res_q.push_back('{got: out_text, exp: cur_exp, lat: lat_cur, n_en: en_cnt,
                          rounds_ok: rounds_ok, stab_ok: stab_ok, hold_ok: hold_ok});
        hs_cnt++;
      end
      prev_ov = out_valid;
    end
  end

  int           res_rd = 0;
  logic [127:0] last_got = '0;

  task automatic check_results();
    while (res_rd < res_q.size()) begin
      res_t r;
      r = res_q[res_rd];
      res_rd++;
      check_value("out_text", r.got, r.exp);
      check_value("latency", 128'(r.lat), 128'(LATENCY));
      check_value("enable_count", 128'(r.n_en), 128'(NUM_ROUNDS));
      check_value("round_sequence", 128'(r.rounds_ok), 128'd1);
      check_value("core_in_stable", 128'(r.stab_ok), 128'd1);
      check_value("out_hold", 128'(r.hold_ok), 128'd1);
      last_got = r.got;
    end
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key);
    int n;
    n = 0;
    in_text = pt; in_key = key; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_value("accept_bound", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit rand_ready);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 1000) begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check_value("out_bound", 128'(done), 128'd1);
  endtask

  task automatic check_blk_cnt(input string tag);
    @(negedge clk); #1;
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    check_value(tag, 128'(blk_cnt), 128'(hs_cnt));
`else
    check_value(tag, 128'(blk_cnt), 128'd0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [127:0] held;
    int           n, acc0, wd0, d;
    bit           ok, hit;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    rst = 1'b1; in_valid = 1'b0; in_text = '0; in_key = '0; out_ready = 1'b0; core_hang = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_in_ready", 128'(in_ready), 128'd1);
    check_value("rst_out_valid", 128'(out_valid), 128'd0);
    check_value("rst_busy", 128'(busy), 128'd0);
    check_value("rst_wdog_err", 128'(wdog_err), 128'd0);
    check_value("rst_core_enable", 128'(core_enable), 128'd0);
    check_value("rst_out_text", out_text, 128'd0);
    check_value("rst_core_text", core_text, 128'd0);
    check_value("rst_core_key", core_key, 128'd0);
    check_value("rst_core_round", 128'(core_round), 128'd0);
    check_value("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_block(C1_PT, C1_KEY);
    wait_out(1'b0);
    check_results();
    check_value("c1_ciphertext", last_got, C1_CT);

    send_block(AB_PT, AB_KEY);
    wait_out(1'b1);
    check_results();
    check_value("appb_ciphertext", last_got, AB_CT);

    for (int b = 0; b < 5; b++) begin
      send_block(rand128(), rand128());
      wait_out(1'b1);
      check_results();
    end
    check_blk_cnt("blk_cnt_after_random");

    // Back-pressure with a second block waiting at the input
    send_block(rand128(), rand128());
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_value("bp_valid_seen", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    in_text = rand128(); in_key = rand128(); in_valid = 1'b1;
    acc0 = acc_cnt; held = out_text; ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (out_text !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 0;
    end
    check_value("bp_stall_hold", 128'(ok), 128'd1);
    check_value("bp_no_accept", 128'(acc_cnt), 128'(acc0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk); #1;
    check_value("bp_ready_after_hs", 128'(in_ready), 128'd1);
    check_value("bp_accept_next", 128'(acc_cnt), 128'(acc0 + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(1'b1);
    check_results();
    check_blk_cnt("blk_cnt_after_bp");

    // Reset in the middle of round 5
    send_block(C1_PT, C1_KEY);
    n = 0; hit = 0;
    while (!hit && n < 400) begin
      @(negedge clk);
      if (core_enable && core_round == 4'd5) hit = 1;
      n++;
    end
    check_value("reach_round5", 128'(hit), 128'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_value("midrst_out_valid", 128'(out_valid), 128'd0);
    check_value("midrst_busy", 128'(busy), 128'd0);
    check_value("midrst_core_round", 128'(core_round), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("postrst_out_valid", 128'(out_valid), 128'd0);
    check_value("postrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    check_value("postrst_no_result", 128'(res_q.size()), 128'(res_rd));
    send_block(C1_PT, C1_KEY);
    wait_out(1'b1);
    check_results();
    check_value("postrst_c1_ciphertext", last_got, C1_CT);
    for (int b = 0; b < 2; b++) begin
      send_block(rand128(), rand128());
      wait_out(1'b0);
      check_results();
    end
    check_blk_cnt("blk_cnt_three_blocks");

    // Hung core: watchdog abort
    core_hang = 1'b1;
    wd0 = wd_q.size();
    acc0 = res_q.size();
    send_block(rand128(), rand128());
    n = 0;
    while (!wdog_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_value("wdog_seen", 128'(wdog_err), 128'd1);
    @(negedge clk); #1;
    d = (wd_q.size() > 0) ? wd_q[wd_q.size() - 1] : -1;
    check_value("wdog_pulses", 128'(wd_q.size()), 128'(wd0 + 1));
    check_value("wdog_delay", 128'(d), 128'(WDOG));
    check_value("wdog_single_cycle", 128'(wdog_err), 128'd0);
    check_value("wdog_busy", 128'(busy), 128'd0);
    check_value("wdog_in_ready", 128'(in_ready), 128'd1);
    check_value("wdog_no_output", 128'(out_valid), 128'd0);
    repeat (30) @(negedge clk);
    check_value("wdog_discarded", 128'(res_q.size()), 128'(acc0));
    @(posedge clk); #1;
    core_hang = 1'b0;
    send_block(AB_PT, AB_KEY);
    wait_out(1'b1);
    check_results();
    check_value("recover_appb", last_got, AB_CT);
    check_blk_cnt("blk_cnt_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
